// File: rtl/bcd_display_driver.sv
// bcd_display_driver
//   Takes one 8-bit binary value per start/ready handshake and converts it to
//   three BCD digits with a sequential shift-and-add-3 (double-dabble) engine,
//   one shift per cycle. It drives a time-multiplexed, three-digit, common-anode
//   7-segment display from the last completed result, so the display never
//   shows a partial conversion.
//
//   Parameters:
//     SCAN_DIV  clock cycles each digit stays enabled (>= 2)
//   Ports:
//     clk, rst  clock; asynchronous active-high reset
//     start     load request, taken only when ready=1
//     number    8-bit binary value, sampled on the accepting edge
//     ready     block is idle and will accept start
//     done      one-cycle pulse when bcd is updated
//     bcd       {hundreds, tens, ones}, 4 bits each
//     seg       active-low segments {g,f,e,d,c,b,a}
//     an        active-low digit enables (bit0 ones, bit1 tens, bit2 hundreds)
//   Build option:
//     BCD_LEADING_ZERO_BLANK_EN  blank the leading zero digits (the ones digit
//                                is never blanked)
module bcd_display_driver #(
    parameter int SCAN_DIV = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [7:0]  number,
    output logic        ready,
    output logic        done,
    output logic [11:0] bcd,
    output logic [6:0]  seg,
    output logic [2:0]  an
);

    localparam int PW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;

    typedef enum logic [1:0] {S_IDLE, S_CONV, S_DONE} state_t;

    state_t        state, state_nxt;
    logic [7:0]    shreg;
    logic [11:0]   scratch;
    logic [11:0]   adj;
    logic [2:0]    cnt;
    logic [PW-1:0] pre;
    logic [1:0]    idx;
    logic [3:0]    nib;
    logic          blank;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start) state_nxt = S_CONV;
            S_CONV:  if (cnt == 3'd7) state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        ready = (state == S_IDLE);
    end

    // Add-3 correction per nibble, applied before the shift. Each nibble stays
    // <= 9 after every shift, so the 4-bit sum never overflows.
    for (genvar d = 0; d < 3; d++) begin : g_adj
        assign adj[4*d +: 4] = (scratch[4*d +: 4] >= 4'd5) ? scratch[4*d +: 4] + 4'd3
                                                            : scratch[4*d +: 4];
    end

    // Conversion datapath and result register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shreg   <= '0;
            scratch <= '0;
            cnt     <= '0;
            bcd     <= '0;
            done    <= 1'b0;
        end else begin
            done <= (state == S_DONE);
            case (state)
                S_IDLE: if (start) begin
                    shreg   <= number;
                    scratch <= '0;
                    cnt     <= '0;
                end
                S_CONV: begin
                    {scratch, shreg} <= {adj[10:0], shreg, 1'b0};
                    cnt              <= cnt + 3'd1;
                end
                S_DONE: bcd <= scratch;
                default: ;
            endcase
        end
    end

    // Display scan: free-running, independent of the conversion FSM
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre <= '0;
            idx <= '0;
        end else if (pre == PW'(SCAN_DIV - 1)) begin
            pre <= '0;
            idx <= (idx == 2'd2) ? 2'd0 : idx + 2'd1;
        end else begin
            pre <= pre + PW'(1);
        end
    end

    // Digit select, optional leading-zero blanking, and segment decode
    always_comb begin
        an = ~(3'b001 << idx);
        case (idx)
            2'd0:    nib = bcd[3:0];
            2'd1:    nib = bcd[7:4];
            default: nib = bcd[11:8];
        endcase
`ifdef BCD_LEADING_ZERO_BLANK_EN
        blank = ((idx == 2'd2) && (bcd[11:8] == 4'd0)) ||
                ((idx == 2'd1) && (bcd[11:8] == 4'd0) && (bcd[7:4] == 4'd0));
`else
        blank = 1'b0;
`endif
        case (nib)
            4'd0:    seg = 7'b1000000;
            4'd1:    seg = 7'b1111001;
            4'd2:    seg = 7'b0100100;
            4'd3:    seg = 7'b0110000;
            4'd4:    seg = 7'b0011001;
            4'd5:    seg = 7'b0010010;
            4'd6:    seg = 7'b0000010;
            4'd7:    seg = 7'b1111000;
            4'd8:    seg = 7'b0000000;
            4'd9:    seg = 7'b0010000;
            default: seg = 7'b1111111;
        endcase
        if (blank) seg = 7'b1111111;
    end

endmodule
